// File: rtl/bcd2bin_16_if.sv
// Handshake and data bundle for the five-digit BCD to 16-bit binary converter.
// master drives the request and digits, slave returns the result.
interface bcd2bin_16_if;
    logic        start;
    logic [3:0]  BCD_0;
    logic [3:0]  BCD_1;
    logic [3:0]  BCD_2;
    logic [3:0]  BCD_3;
    logic [3:0]  BCD_4;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start,
        output BCD_0,
        output BCD_1,
        output BCD_2,
        output BCD_3,
        output BCD_4,
        input  bin,
        input  busy,
        input  done,
        input  error
    );

    modport slave (
        input  start,
        input  BCD_0,
        input  BCD_1,
        input  BCD_2,
        input  BCD_3,
        input  BCD_4,
        output bin,
        output busy,
        output done,
        output error
    );
endinterface

// File: rtl/bcd2bin_16.sv
// Sequential BCD to binary converter: five digits, multiply-by-10-and-add,
// saturating at 16'hFFFF with error on bad digits or values above 65535.
module bcd2bin_16 (
    input  logic          CLOCK_50,
    input  logic          RESET_N,
    bcd2bin_16_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FAIL = 2'd2
    } state_t;

    state_t      state;
    logic [16:0] acc;
    logic [2:0]  idx;
    logic [3:0]  dig0;
    logic [3:0]  dig1;
    logic [3:0]  dig2;
    logic [3:0]  dig3;
    logic [3:0]  dig4;

    logic [3:0]  cur_dig;
    logic [16:0] acc_nxt;
    logic        in_bad;

    // Select the digit for this step and form the next accumulator value.
    always_comb begin
        cur_dig = 4'd0;
        unique case (idx)
            3'd0:    cur_dig = dig0;
            3'd1:    cur_dig = dig1;
            3'd2:    cur_dig = dig2;
            3'd3:    cur_dig = dig3;
            3'd4:    cur_dig = dig4;
            default: cur_dig = 4'd0;
        endcase
        acc_nxt = (acc * 17'd10) + {13'd0, cur_dig};
        in_bad  = (bus.BCD_0 > 4'd9) || (bus.BCD_1 > 4'd9)
               || (bus.BCD_2 > 4'd9) || (bus.BCD_3 > 4'd9)
               || (bus.BCD_4 > 4'd9);
    end

    // Control FSM and datapath; all outputs are registered here.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            acc       <= 17'd0;
            idx       <= 3'd0;
            dig0      <= 4'd0;
            dig1      <= 4'd0;
            dig2      <= 4'd0;
            dig3      <= 4'd0;
            dig4      <= 4'd0;
            bus.bin   <= 16'h0000;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.error <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dig0     <= bus.BCD_0;
                        dig1     <= bus.BCD_1;
                        dig2     <= bus.BCD_2;
                        dig3     <= bus.BCD_3;
                        dig4     <= bus.BCD_4;
                        acc      <= 17'd0;
                        idx      <= 3'd4;
                        bus.busy <= 1'b1;
                        state    <= in_bad ? FAIL : CONV;
                    end
                end
                CONV: begin
                    acc <= acc_nxt;
                    if (idx == 3'd0) begin
                        if (acc_nxt > 17'd65535) begin
                            bus.bin   <= 16'hFFFF;
                            bus.error <= 1'b1;
                        end else begin
                            bus.bin   <= acc_nxt[15:0];
                            bus.error <= 1'b0;
                        end
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        idx <= idx - 3'd1;
                    end
                end
                FAIL: begin
                    bus.bin   <= 16'hFFFF;
                    bus.error <= 1'b1;
                    bus.done  <= 1'b1;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_16.sv
// Randomised self-checking bench for bcd2bin_16 against an arithmetic
// reference model of the BCD value and its saturation rules.
module tb_bcd2bin_16;

    logic CLOCK_50;
    logic RESET_N;
    int   n_checks;
    int   n_fail;

    bcd2bin_16_if bus ();

    bcd2bin_16 dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .bus      (bus.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Reference: plain decimal value, bad digit or overflow saturates.
    function automatic logic [16:0] model(input logic [3:0] d4,
                                          input logic [3:0] d3,
                                          input logic [3:0] d2,
                                          input logic [3:0] d1,
                                          input logic [3:0] d0);
        int v;
        if (d0 > 9 || d1 > 9 || d2 > 9 || d3 > 9 || d4 > 9)
            return {1'b1, 16'hFFFF};
        v = d4 * 10000 + d3 * 1000 + d2 * 100 + d1 * 10 + d0;
        if (v > 65535)
            return {1'b1, 16'hFFFF};
        return {1'b0, 16'(v)};
    endfunction

    task automatic set_digits(input logic [3:0] d4, input logic [3:0] d3,
                              input logic [3:0] d2, input logic [3:0] d1,
                              input logic [3:0] d0);
        bus.BCD_4 = d4;
        bus.BCD_3 = d3;
        bus.BCD_2 = d2;
        bus.BCD_1 = d1;
        bus.BCD_0 = d0;
    endtask

    // Pulse start with the given digits; report edges-to-done and busy cycles.
    task automatic do_conv(input logic [3:0] d4, input logic [3:0] d3,
                           input logic [3:0] d2, input logic [3:0] d1,
                           input logic [3:0] d0,
                           output int lat, output int busy_cnt,
                           output logic [15:0] b, output logic e);
        @(negedge CLOCK_50);
        set_digits(d4, d3, d2, d1, d0);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!bus.done && lat < 20) begin
            if (bus.busy) busy_cnt++;
            @(negedge CLOCK_50);
            lat++;
        end
        b = bus.bin;
        e = bus.error;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        bus.start = 1'b0;
        set_digits(0, 0, 0, 0, 0);
        repeat (3) @(negedge CLOCK_50);
        n_checks++;
        if ({bus.bin, bus.busy, bus.done, bus.error} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outs got bin=%h busy=%b done=%b err=%b want 0",
                     bus.bin, bus.busy, bus.done, bus.error);
        end
        RESET_N = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        n_checks++;
        if ({bus.bin, bus.busy, bus.done, bus.error} !== 19'd0) begin
            n_fail++;
            $display("FAIL idle_outs got bin=%h busy=%b done=%b err=%b want 0",
                     bus.bin, bus.busy, bus.done, bus.error);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        logic [15:0] b;
        logic e;
        do_conv(1, 2, 3, 4, 5, lat, bc, b, e);
        n_checks++;
        if (lat !== 6) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 6", lat);
        end
        n_checks++;
        if (bc !== 5) begin
            n_fail++;
            $display("FAIL basic_busy_cycles got %0d want 5", bc);
        end
        n_checks++;
        if ({e, b} !== {1'b0, 16'h3039}) begin
            n_fail++;
            $display("FAIL basic_result got err=%b bin=%h want 0 3039", e, b);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_busy_at_done got %b want 0", bus.busy);
        end
        @(negedge CLOCK_50);
        n_checks++;
        if ({bus.done, bus.bin} !== {1'b0, 16'h3039}) begin
            n_fail++;
            $display("FAIL basic_hold got done=%b bin=%h want 0 3039",
                     bus.done, bus.bin);
        end
    endtask

    task automatic test_boundaries();
        logic [3:0] tbl [3][5];
        logic [16:0] exp;
        int lat, bc;
        logic [15:0] b;
        logic e;
        tbl[0] = '{4'd6, 4'd5, 4'd5, 4'd3, 4'd5};
        tbl[1] = '{4'd6, 4'd5, 4'd5, 4'd3, 4'd6};
        tbl[2] = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        for (int i = 0; i < 3; i++) begin
            exp = model(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4]);
            do_conv(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], tbl[i][4],
                    lat, bc, b, e);
            n_checks++;
            if ({lat, e, b} !== {32'd6, exp}) begin
                n_fail++;
                $display("FAIL boundary_%0d got lat=%0d err=%b bin=%h want 6 %b %h",
                         i, lat, e, b, exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_invalid();
        int lat, bc;
        logic [15:0] b;
        logic e;
        do_conv(0, 0, 4'hA, 0, 0, lat, bc, b, e);
        n_checks++;
        if ({lat, bc} !== {32'd2, 32'd1}) begin
            n_fail++;
            $display("FAIL invalid_timing got lat=%0d busy=%0d want 2 1", lat, bc);
        end
        n_checks++;
        if ({e, b} !== {1'b1, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL invalid_result got err=%b bin=%h want 1 ffff", e, b);
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        @(negedge CLOCK_50);
        set_digits(0, 0, 0, 4, 2);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        set_digits(9, 9, 9, 9, 9);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                dones++;
                n_checks++;
                if ({bus.error, bus.bin} !== {1'b0, 16'h002A}) begin
                    n_fail++;
                    $display("FAIL ignore_result got err=%b bin=%h want 0 002a",
                             bus.error, bus.bin);
                end
            end
            @(negedge CLOCK_50);
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, t1, t2, dones;
        logic [15:0] b1, b2;
        @(negedge CLOCK_50);
        set_digits(0, 0, 0, 0, 7);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        set_digits(0, 0, 1, 0, 0);
        cyc = 1;
        dones = 0;
        t1 = 0;
        t2 = 0;
        b1 = 16'h0;
        b2 = 16'h0;
        while (dones < 2 && cyc < 40) begin
            if (bus.done) begin
                if (dones == 0) begin
                    t1 = cyc;
                    b1 = bus.bin;
                end else begin
                    t2 = cyc;
                    b2 = bus.bin;
                    bus.start = 1'b0;
                end
                dones++;
            end
            if (dones < 2) begin
                @(negedge CLOCK_50);
                cyc++;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if ({dones, t2 - t1} !== {32'd2, 32'd6}) begin
            n_fail++;
            $display("FAIL b2b_spacing got dones=%0d gap=%0d want 2 6",
                     dones, t2 - t1);
        end
        n_checks++;
        if ({b1, b2} !== {16'h0007, 16'h0064}) begin
            n_fail++;
            $display("FAIL b2b_values got %h %h want 0007 0064", b1, b2);
        end
        repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic test_random();
        logic [3:0] d [5];
        logic [16:0] exp;
        int lat, bc, want_lat;
        logic [15:0] b;
        logic e;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 5; k++) begin
                if ($urandom_range(0, 7) == 0)
                    d[k] = 4'($urandom_range(0, 15));
                else
                    d[k] = 4'($urandom_range(0, 9));
            end
            if (n % 4 == 0) d[0] = 4'($urandom_range(5, 9));
            exp = model(d[0], d[1], d[2], d[3], d[4]);
            want_lat = (d[0] > 9 || d[1] > 9 || d[2] > 9 ||
                        d[3] > 9 || d[4] > 9) ? 2 : 6;
            do_conv(d[0], d[1], d[2], d[3], d[4], lat, bc, b, e);
            n_checks++;
            if ({lat, e, b} !== {want_lat, exp}) begin
                n_fail++;
                $display("FAIL random_%0d digits=%h%h%h%h%h got lat=%0d err=%b bin=%h want %0d %b %h",
                         n, d[0], d[1], d[2], d[3], d[4], lat, e, b,
                         want_lat, exp[16], exp[15:0]);
            end
        end
    endtask

    task automatic test_async_reset();
        int dones, lat, bc;
        logic [15:0] b;
        logic e;
        @(negedge CLOCK_50);
        set_digits(1, 2, 3, 4, 5);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        @(negedge CLOCK_50);
        #2 RESET_N = 1'b0;
        #1;
        n_checks++;
        if ({bus.bin, bus.busy, bus.done, bus.error} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset got bin=%h busy=%b done=%b err=%b want 0",
                     bus.bin, bus.busy, bus.done, bus.error);
        end
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            if (bus.done || bus.busy) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL async_no_done got %0d active cycles want 0", dones);
        end
        do_conv(0, 0, 0, 0, 0, lat, bc, b, e);
        n_checks++;
        if ({lat, e, b} !== {32'd6, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_fresh got lat=%0d err=%b bin=%h want 6 0 0000",
                     lat, e, b);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_invalid();
        test_ignore_start();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
